// File: rtl/scan_bist_ctrl_pkg.sv
// Shared definitions for the scan BIST controller.
//   state_e     : controller FSM states
//   poly_terms  : low-order terms of a maximal-length polynomial per width
//   lfsr_taps   : Fibonacci right-shift tap mask (feedback into MSB)
//   misr_taps   : left-shift MISR tap mask (feedback into LSB)
// For width 16 the polynomial is x^16+x^14+x^13+x^11+1, giving
// lfsr_taps(16) = 16'h002D and misr_taps(16) = 16'hB400.
package scan_bist_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_CAPTURE,
    ST_UNLOAD,
    ST_DONE
  } state_e;

  // Bit k set for every term x^k (0 <= k < w) besides the leading x^w.
  function automatic logic [63:0] poly_terms(input int w);
    logic [63:0] p;
    p = '0;
    case (w)
      4:       begin p[3]  = 1'b1; p[0] = 1'b1; end
      8:       begin p[6]  = 1'b1; p[5] = 1'b1; p[4] = 1'b1; p[0] = 1'b1; end
      16:      begin p[14] = 1'b1; p[13] = 1'b1; p[11] = 1'b1; p[0] = 1'b1; end
      24:      begin p[23] = 1'b1; p[22] = 1'b1; p[17] = 1'b1; p[0] = 1'b1; end
      32:      begin p[22] = 1'b1; p[2] = 1'b1; p[1] = 1'b1; p[0] = 1'b1; end
      default: begin p[w-1] = 1'b1; p[0] = 1'b1; end
    endcase
    return p;
  endfunction

  // Right-shifting register: term x^k maps to tap bit (w-k).
  function automatic logic [63:0] lfsr_taps(input int w);
    logic [63:0] p, t;
    p = poly_terms(w);
    t = '0;
    t[0] = 1'b1;
    for (int k = 1; k < 64; k++)
      if (k < w && p[k]) t[w-k] = 1'b1;
    return t;
  endfunction

  // Left-shifting register: term x^k maps to tap bit (k-1).
  function automatic logic [63:0] misr_taps(input int w);
    logic [63:0] p, t;
    p = poly_terms(w);
    t = '0;
    t[w-1] = 1'b1;
    for (int k = 1; k < 64; k++)
      if (k < w && p[k]) t[k-1] = 1'b1;
    return t;
  endfunction

endpackage

// File: rtl/scan_bist_ctrl_if.sv
// Bundle between the BIST controller, the scan core and the run requester.
//   start            : one-cycle run request
//   scan_se/scan_si  : scan enable / serial scan-in to chain head
//   scan_so          : serial scan-out from chain tail
//   pi / po          : core primary inputs / outputs
//   busy/done/pass   : run status
//   signature        : final MISR value
// master = controller side, slave = core + requester side.
interface scan_bist_ctrl_if #(
  parameter int N_PI   = 4,
  parameter int N_PO   = 1,
  parameter int MISR_W = 16
);
  logic              start;
  logic              scan_se;
  logic              scan_si;
  logic              scan_so;
  logic [N_PI-1:0]   pi;
  logic [N_PO-1:0]   po;
  logic              busy;
  logic              done;
  logic              pass;
  logic [MISR_W-1:0] signature;

  modport master (
    input  start, scan_so, po,
    output scan_se, scan_si, pi, busy, done, pass, signature
  );

  modport slave (
    output start, scan_so, po,
    input  scan_se, scan_si, pi, busy, done, pass, signature
  );
endinterface

// File: rtl/scan_bist_ctrl_misr.sv
// bist_misr: multiple-input signature register.
//   CK, RSTN : clock, async active-low reset (register -> 0)
//   en       : compact din this cycle
//   clr      : synchronous clear (wins over en)
//   din      : parallel data folded into the register
//   nxt      : value the register takes if en is high this cycle
module bist_misr #(
  parameter int           W    = 16,
  parameter logic [W-1:0] TAPS = '0
) (
  input  logic         CK,
  input  logic         RSTN,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] din,
  output logic [W-1:0] nxt
);

  logic [W-1:0] q;

  assign nxt = {q[W-2:0], ^(q & TAPS)} ^ din;

  always_ff @(posedge CK or negedge RSTN) begin
    if (!RSTN)    q <= '0;
    else if (clr) q <= '0;
    else if (en)  q <= nxt;
  end

endmodule

// File: rtl/scan_bist_ctrl.sv
// scan_bist_ctrl: scan BIST controller for a single muxed-D scan chain.
// An LFSR feeds scan-in bits during SHIFT and primary inputs during
// CAPTURE; scan-out and primary outputs are compacted into a MISR whose
// final value is reported as the signature.
//   CK, RSTN : clock (rising edge), async active-low reset
//   bus      : scan_bist_ctrl_if.master (start, scan_se/si/so, pi, po,
//              busy, done, pass, signature)
// Option macro SCAN_BIST_SIG_COMPARE_EN: when defined, pass is registered
// with done as (signature == GOLDEN_SIG); otherwise pass is tied low and
// the signature is left for an off-chip compare.
module scan_bist_ctrl
  import scan_bist_ctrl_pkg::*;
#(
  parameter int                CHAIN_LEN  = 3,
  parameter int                N_PI       = 4,
  parameter int                N_PO       = 1,
  parameter int                N_PATTERNS = 16,
  parameter int                LFSR_W     = 16,
  parameter int                MISR_W     = 16,
  parameter logic [LFSR_W-1:0] LFSR_SEED  = 16'hACE1,
  parameter logic [MISR_W-1:0] GOLDEN_SIG = 16'h0000
) (
  input logic              CK,
  input logic              RSTN,
  scan_bist_ctrl_if.master bus
);

  localparam int PCW = $clog2(N_PATTERNS + 1);
  localparam int BCW = (CHAIN_LEN > 1) ? $clog2(CHAIN_LEN) : 1;
  localparam logic [LFSR_W-1:0] LFSR_TAPS = LFSR_W'(lfsr_taps(LFSR_W));
  localparam logic [MISR_W-1:0] MISR_TAPS = MISR_W'(misr_taps(MISR_W));

  state_e              state_q, state_d;
  logic [BCW-1:0]      bit_q;
  logic [PCW-1:0]      pat_q;
  logic [LFSR_W-1:0]   lfsr_q, lfsr_step;
  logic [N_PI-1:0]     pi_q;
  logic                done_q;
  logic [MISR_W-1:0]   sig_q, misr_din, misr_nxt;
  logic                in_shift, in_cap, in_unload;
  logic                start_run, last_bit, last_pat, unload_end, misr_en;

  assign in_shift   = (state_q == ST_SHIFT);
  assign in_cap     = (state_q == ST_CAPTURE);
  assign in_unload  = (state_q == ST_UNLOAD);
  assign start_run  = bus.start && (state_q == ST_IDLE || state_q == ST_DONE);
  assign last_bit   = (bit_q == BCW'(CHAIN_LEN - 1));
  assign last_pat   = (pat_q == PCW'(N_PATTERNS - 1));
  assign unload_end = in_unload && last_bit;

  assign lfsr_step = {^(lfsr_q & LFSR_TAPS), lfsr_q[LFSR_W-1:1]};

  // ---------------- FSM ----------------
  always_ff @(posedge CK or negedge RSTN) begin
    if (!RSTN) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DONE: if (bus.start) state_d = ST_SHIFT;
      ST_SHIFT:         if (last_bit)  state_d = ST_CAPTURE;
      ST_CAPTURE:       state_d = last_pat ? ST_UNLOAD : ST_SHIFT;
      ST_UNLOAD:        if (last_bit)  state_d = ST_DONE;
      default:          state_d = ST_IDLE;
    endcase
  end

  // Bit counter runs through each SHIFT/UNLOAD phase and rests at 0.
  always_ff @(posedge CK or negedge RSTN) begin
    if (!RSTN)                     bit_q <= '0;
    else if (in_shift || in_unload) bit_q <= last_bit ? '0 : bit_q + BCW'(1);
    else                           bit_q <= '0;
  end

  // Patterns captured so far; zero marks the first, uncompacted load.
  always_ff @(posedge CK or negedge RSTN) begin
    if (!RSTN)          pat_q <= '0;
    else if (start_run) pat_q <= '0;
    else if (in_cap && pat_q != PCW'(N_PATTERNS)) pat_q <= pat_q + PCW'(1);
  end

  always_ff @(posedge CK or negedge RSTN) begin
    if (!RSTN)                   lfsr_q <= LFSR_SEED;
    else if (start_run)          lfsr_q <= LFSR_SEED;
    else if (in_shift || in_cap) lfsr_q <= lfsr_step;
  end

  always_ff @(posedge CK or negedge RSTN) begin
    if (!RSTN)       pi_q <= '0;
    else if (in_cap) pi_q <= lfsr_q[N_PI:1];
  end

  // ---------------- compaction ----------------
  always_comb begin
    misr_din    = '0;
    misr_din[0] = bus.scan_so;
    if (!in_unload) misr_din[N_PO:1] = bus.po;
  end

  assign misr_en = (in_shift && pat_q != '0) || in_cap || in_unload;

  bist_misr #(.W(MISR_W), .TAPS(MISR_TAPS)) u_misr (
    .CK  (CK),
    .RSTN(RSTN),
    .en  (misr_en),
    .clr (start_run),
    .din (misr_din),
    .nxt (misr_nxt)
  );

  // Signature takes the MISR value including the final unload bit.
  always_ff @(posedge CK or negedge RSTN) begin
    if (!RSTN) begin
      done_q <= 1'b0;
      sig_q  <= '0;
    end else if (start_run) begin
      done_q <= 1'b0;
    end else if (unload_end) begin
      done_q <= 1'b1;
      sig_q  <= misr_nxt;
    end
  end

`ifdef SCAN_BIST_SIG_COMPARE_EN
  logic pass_q;
  always_ff @(posedge CK or negedge RSTN) begin
    if (!RSTN)           pass_q <= 1'b0;
    else if (start_run)  pass_q <= 1'b0;
    else if (unload_end) pass_q <= (misr_nxt == GOLDEN_SIG);
  end
  assign bus.pass = pass_q;
`else
  // No comparator; GOLDEN_SIG is only referenced to keep it visible.
  logic unused_golden;
  assign unused_golden = ^GOLDEN_SIG;
  assign bus.pass      = 1'b0;
`endif

  // ---------------- outputs ----------------
  assign bus.scan_se   = !in_cap;
  assign bus.scan_si   = in_shift && lfsr_q[0];
  assign bus.pi        = in_cap ? lfsr_q[N_PI:1] : pi_q;
  assign bus.busy      = in_shift || in_cap || in_unload;
  assign bus.done      = done_q;
  assign bus.signature = sig_q;

endmodule
